// File: rtl/match_scoreboard.sv
// Match scoreboard for full_game: counts game wins per player, restarts each game via
// game_init after a settle delay, and declares a match winner. Optional MATCH_STREAK_EN adds a win-streak output.
module match_scoreboard #(
  parameter int WINS_TO_MATCH = 3,
  parameter int SCORE_W       = 4,
  parameter int RESTART_DELAY = 8,
  parameter int INIT_LEN      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               gameover,
  input  logic               who,
  input  logic               new_match,
  output logic               game_init,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [SCORE_W-1:0] games_played,
  output logic               match_over,
  output logic               match_winner
`ifdef MATCH_STREAK_EN
  ,
  output logic [SCORE_W-1:0] streak
`endif
);

  localparam int CMAX  = (RESTART_DELAY > INIT_LEN) ? RESTART_DELAY : INIT_LEN;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [CNT_W-1:0]   INIT_LAST = CNT_W'(INIT_LEN - 1);
  localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'(RESTART_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN_V     = SCORE_W'(WINS_TO_MATCH);

  typedef enum logic [1:0] {S_INIT, S_PLAY, S_WAIT, S_END} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               gov_q;
  logic               rise;
  logic [SCORE_W-1:0] a_inc, b_inc, gp_inc;
  logic               hit;

  assign rise      = gameover & ~gov_q;
  assign a_inc     = score_a + SCORE_W'(1);
  assign b_inc     = score_b + SCORE_W'(1);
  assign gp_inc    = (&games_played) ? games_played : games_played + SCORE_W'(1);
  assign hit       = who ? (b_inc == WIN_V) : (a_inc == WIN_V);
  assign game_init = (state == S_INIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_INIT;
      cnt          <= '0;
      gov_q        <= 1'b0;
      score_a      <= '0;
      score_b      <= '0;
      games_played <= '0;
      match_over   <= 1'b0;
      match_winner <= 1'b0;
    end else begin
      gov_q <= gameover;
      // new_match overrides everything, including a coincident game result
      if (new_match) begin
        state        <= S_INIT;
        cnt          <= '0;
        score_a      <= '0;
        score_b      <= '0;
        games_played <= '0;
        match_over   <= 1'b0;
        match_winner <= 1'b0;
      end else begin
        case (state)
          S_INIT: begin
            if (cnt == INIT_LAST) begin
              state <= S_PLAY;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_PLAY: begin
            if (rise) begin
              if (who) score_b <= b_inc;
              else     score_a <= a_inc;
              games_played <= gp_inc;
              cnt          <= '0;
              if (hit) begin
                state        <= S_END;
                match_over   <= 1'b1;
                match_winner <= who;
              end else begin
                state <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (cnt == WAIT_LAST) begin
              state <= S_INIT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_END: ;
          default: state <= S_INIT;
        endcase
      end
    end
  end

`ifdef MATCH_STREAK_EN
  logic last_who;

  // games_played == 0 marks the first game of a match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak   <= '0;
      last_who <= 1'b0;
    end else if (new_match) begin
      streak   <= '0;
      last_who <= 1'b0;
    end else if (state == S_PLAY && rise) begin
      last_who <= who;
      if (games_played == '0 || who != last_who) streak <= SCORE_W'(1);
      else if (!(&streak))                       streak <= streak + SCORE_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_match_scoreboard.sv
// Bench for match_scoreboard: fixed vector table, directed corner sequences, and random
// stimulus checked against a phase/countdown reference model.
module tb_match_scoreboard;
  localparam int SW = 4, WINS = 3, DLY = 8, IL = 2;

  logic clk = 1'b0, rst_n = 1'b0, gameover = 1'b0, who = 1'b0, new_match = 1'b0;
  logic game_init, match_over, match_winner;
  logic [SW-1:0] score_a, score_b, games_played;
`ifdef MATCH_STREAK_EN
  logic [SW-1:0] streak;
`endif

  always #5 clk = ~clk;

  match_scoreboard #(.WINS_TO_MATCH(WINS), .SCORE_W(SW), .RESTART_DELAY(DLY), .INIT_LEN(IL)) dut (
    .clk(clk), .rst_n(rst_n), .gameover(gameover), .who(who), .new_match(new_match),
    .game_init(game_init), .score_a(score_a), .score_b(score_b),
    .games_played(games_played), .match_over(match_over), .match_winner(match_winner)
`ifdef MATCH_STREAK_EN
    , .streak(streak)
`endif
  );

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: phase 0=init 1=play 2=wait 3=match end, m_left = cycles remaining
  int m_ph, m_left, m_a, m_b, m_gp, m_mo, m_mw, m_prev, m_streak, m_last;

  task automatic m_clear();
    m_a = 0; m_b = 0; m_gp = 0; m_mo = 0; m_mw = 0; m_streak = 0; m_last = -1;
  endtask

  task automatic m_reset();
    m_clear(); m_ph = 0; m_left = IL; m_prev = 0;
  endtask

  task automatic m_step(input int go, input int w, input int nm);
    bit r;
    r = (go == 1) && (m_prev == 0);
    m_prev = go;
    if (nm == 1) begin
      m_clear(); m_ph = 0; m_left = IL;
    end else begin
      case (m_ph)
        0: begin m_left--; if (m_left == 0) m_ph = 1; end
        1: if (r) begin
          if (w == 1) m_b++; else m_a++;
          if (m_gp < (1 << SW) - 1) m_gp++;
          if (m_last == w) m_streak = (m_streak < (1 << SW) - 1) ? m_streak + 1 : m_streak;
          else m_streak = 1;
          m_last = w;
          if (((w == 1) ? m_b : m_a) == WINS) begin m_ph = 3; m_mo = 1; m_mw = w; end
          else begin m_ph = 2; m_left = DLY; end
        end
        2: begin m_left--; if (m_left == 0) begin m_ph = 0; m_left = IL; end end
        default: ;
      endcase
    end
  endtask

  task automatic chk_all();
    chk("game_init", 32'(game_init), 32'(m_ph == 0));
    chk("score_a", 32'(score_a), m_a);
    chk("score_b", 32'(score_b), m_b);
    chk("games_played", 32'(games_played), m_gp);
    chk("match_over", 32'(match_over), m_mo);
    chk("match_winner", 32'(match_winner), m_mw);
`ifdef MATCH_STREAK_EN
    chk("streak", 32'(streak), m_streak);
`endif
  endtask

  task automatic cyc(input logic go, input logic w, input logic nm);
    gameover = go; who = w; new_match = nm;
    @(posedge clk);
    m_step(int'(go), int'(w), int'(nm));
    #1;
    chk_all();
    new_match = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    gameover = 1'b0; new_match = 1'b0;
    m_reset();
    #1;
    chk("rst_game_init", 32'(game_init), 1);
    chk("rst_score_a", 32'(score_a), 0);
    chk("rst_score_b", 32'(score_b), 0);
    chk("rst_games_played", 32'(games_played), 0);
    chk("rst_match_over", 32'(match_over), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // steer to PLAY with gameover low, then produce one game result for w
  task automatic win(input logic w);
    for (int i = 0; i < 40 && m_ph != 1; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("play_timeout", m_ph, 1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, w, 1'b0);
  endtask

  typedef struct {
    logic go, w, nm;
    int   rep;
    logic ini;
    int   a, b, gp;
    logic mo;
  } vec_t;
  vec_t tbl[9];

  initial begin
    // reset release, B wins, restart after delay, stuck gameover across INIT->PLAY, then A wins
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1, 1'b1, 0, 0, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 0, 0, 0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 0, 1, 1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 7, 1'b0, 0, 1, 1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 2, 1'b1, 0, 1, 1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 0, 1, 1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 0, 1, 1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 0, 1, 1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1, 1, 2, 1'b0};

    do_reset();
    foreach (tbl[k]) begin
      for (int r = 0; r < tbl[k].rep; r++) begin
        cyc(tbl[k].go, tbl[k].w, tbl[k].nm);
        chk($sformatf("tbl%0d_init", k), 32'(game_init), 32'(tbl[k].ini));
        chk($sformatf("tbl%0d_a", k), 32'(score_a), tbl[k].a);
        chk($sformatf("tbl%0d_b", k), 32'(score_b), tbl[k].b);
        chk($sformatf("tbl%0d_gp", k), 32'(games_played), tbl[k].gp);
        chk($sformatf("tbl%0d_mo", k), 32'(match_over), 32'(tbl[k].mo));
      end
    end

    // match end: A takes three games, later rises are ignored
    cyc(1'b0, 1'b0, 1'b1);
    win(1'b0); win(1'b0); win(1'b0);
    chk("end_score_a", 32'(score_a), 3);
    chk("end_match_over", 32'(match_over), 1);
    chk("end_winner", 32'(match_winner), 0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("hold_score_a", 32'(score_a), 3);
    chk("hold_score_b", 32'(score_b), 0);

    // collision: new_match with a rise at score_a=2
    cyc(1'b0, 1'b0, 1'b1);
    win(1'b0); win(1'b0);
    chk("pre_coll_a", 32'(score_a), 2);
    for (int i = 0; i < 40 && m_ph != 1; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("coll_score_a", 32'(score_a), 0);
    chk("coll_init", 32'(game_init), 1);
    chk("coll_match_over", 32'(match_over), 0);

`ifdef MATCH_STREAK_EN
    cyc(1'b0, 1'b0, 1'b1);
    win(1'b0); chk("streak1", 32'(streak), 1);
    win(1'b0); chk("streak2", 32'(streak), 2);
    win(1'b1); chk("streak3", 32'(streak), 1);
    win(1'b1); chk("streak4", 32'(streak), 2);
    win(1'b1); chk("streak5", 32'(streak), 3);
    cyc(1'b0, 1'b0, 1'b1);
    chk("streak_clr", 32'(streak), 0);
`endif

    // random stimulus against the model, with occasional new_match and mid-run reset
    begin
      logic g = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 799) == 0) do_reset();
        if ($urandom_range(0, 4) == 0) g = ~g;
        cyc(g, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 149) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
